// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-side and data-side MMUs, with a per-transaction watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data side always wins ties.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_bsel,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        err,
  output logic        m_ren,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_bsel,
  input  logic [31:0] m_rdata,
  input  logic        m_done
);

  localparam int unsigned WD_W = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  owner_t         last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [31:0]    i_rdata_q, i_rdata_d;
  logic [31:0]    d_rdata_q, d_rdata_d;
  logic           i_ready_q, i_ready_d;
  logic           d_ready_q, d_ready_d;
  logic           err_q, err_d;
  logic           m_ren_q, m_ren_d;
  logic           m_wen_q, m_wen_d;
  logic [31:0]    m_addr_q, m_addr_d;
  logic [31:0]    m_wdata_q, m_wdata_d;
  logic [3:0]     m_bsel_q, m_bsel_d;
  logic           grant_d_c;
  logic [31:0]    cap_data_c;

  // Arbitration: a lone requester wins; ties depend on the build option.
  always_comb begin
    grant_d_c = 1'b0;
    if (d_req && !i_req) begin
      grant_d_c = 1'b1;
    end else if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_d_c = (last_q == OWN_I);
`else
      grant_d_c = 1'b1;
`endif
    end
  end

  // Writes return zero read data.
  assign cap_data_c = m_wen_q ? 32'h0 : m_rdata;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wd_d      = wd_q;
    i_rdata_d = 32'h0;
    d_rdata_d = 32'h0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    err_d     = 1'b0;
    m_ren_d   = m_ren_q;
    m_wen_d   = m_wen_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_bsel_d  = m_bsel_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_BUSY;
          wd_d    = '0;
          if (grant_d_c) begin
            owner_d   = OWN_D;
            m_ren_d   = !d_wen;
            m_wen_d   = d_wen;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_bsel_d  = d_bsel;
          end else begin
            owner_d   = OWN_I;
            m_ren_d   = 1'b1;
            m_wen_d   = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = 32'h0;
            m_bsel_d  = 4'b1111;
          end
        end
      end

      ST_BUSY: begin
        if (m_done || (wd_q == WD_LAST)) begin
          state_d = ST_RESP;
          m_ren_d = 1'b0;
          m_wen_d = 1'b0;
          err_d   = !m_done;
          if (owner_q == OWN_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = m_done ? cap_data_c : 32'h0;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = m_done ? cap_data_c : 32'h0;
          end
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      wd_q      <= '0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
      m_ren_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      m_bsel_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      err_q     <= err_d;
      m_ren_q   <= m_ren_d;
      m_wen_q   <= m_wen_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_bsel_q  <= m_bsel_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ready = i_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign err     = err_q;
  assign m_ren   = m_ren_q;
  assign m_wen   = m_wen_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_bsel  = m_bsel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus reset, tie, timeout and stray-done sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_bsel = 4'h0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        err;
  logic        m_ren;
  logic        m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_bsel;
  logic [31:0] m_rdata = 32'h0;
  logic        m_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_bsel(d_bsel),
    .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_bsel(m_bsel),
    .m_rdata(m_rdata), .m_done(m_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        side_d;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bsel;
    logic [31:0] mem_rdata;
    int          delay;
    logic        stray_resp;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_bsel;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " i_ready"}, 32'(i_ready), 32'h0);
    chk({tag, " d_ready"}, 32'(d_ready), 32'h0);
    chk({tag, " err"},     32'(err),     32'h0);
    chk({tag, " i_rdata"}, i_rdata,      32'h0);
    chk({tag, " d_rdata"}, d_rdata,      32'h0);
    chk({tag, " m_ren"},   32'(m_ren),   32'h0);
    chk({tag, " m_wen"},   32'(m_wen),   32'h0);
    chk({tag, " m_addr"},  m_addr,       32'h0);
    chk({tag, " m_wdata"}, m_wdata,      32'h0);
    chk({tag, " m_bsel"},  32'(m_bsel),  32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    logic  stable;
    t = $sformatf("vec%0d", idx);
    if (v.side_d) begin
      d_req = 1'b1; d_wen = v.wen; d_addr = v.addr; d_wdata = v.wdata; d_bsel = v.bsel;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
      d_wdata = 32'h5A5A_5A5A; d_bsel = 4'b0101;
    end
    tick();
    chk({t, " m_ren"},   32'(m_ren),  32'(v.exp_ren));
    chk({t, " m_wen"},   32'(m_wen),  32'(v.exp_wen));
    chk({t, " m_addr"},  m_addr,      v.addr);
    chk({t, " m_wdata"}, m_wdata,     v.exp_wdata);
    chk({t, " m_bsel"},  32'(m_bsel), 32'(v.exp_bsel));
    stable = 1'b1;
    for (int j = 0; j < v.delay; j++) begin
      tick();
      if (m_ren !== v.exp_ren || m_wen !== v.exp_wen || m_addr !== v.addr ||
          m_wdata !== v.exp_wdata || m_bsel !== v.exp_bsel || i_ready !== 1'b0 || d_ready !== 1'b0)
        stable = 1'b0;
    end
    chk({t, " hold"}, 32'(stable), 32'h1);
    m_done = 1'b1; m_rdata = v.mem_rdata;
    tick();
    if (v.side_d) begin
      chk({t, " d_ready"}, 32'(d_ready), 32'h1);
      chk({t, " d_rdata"}, d_rdata,      v.exp_rdata);
      chk({t, " i_ready"}, 32'(i_ready), 32'h0);
      chk({t, " i_rdata"}, i_rdata,      32'h0);
    end else begin
      chk({t, " i_ready"}, 32'(i_ready), 32'h1);
      chk({t, " i_rdata"}, i_rdata,      v.exp_rdata);
      chk({t, " d_ready"}, 32'(d_ready), 32'h0);
      chk({t, " d_rdata"}, d_rdata,      32'h0);
    end
    chk({t, " err"},      32'(err),           32'h0);
    chk({t, " resp port"}, 32'(m_ren | m_wen), 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    if (!v.stray_resp) m_done = 1'b0;
    m_rdata = 32'h7777_1111;
    tick();
    chk({t, " pulse end"}, 32'({i_ready, d_ready}), 32'h0);
    chk({t, " idle port"}, 32'(m_ren | m_wen),      32'h0);
    if (v.stray_resp) begin
      m_done = 1'b0;
      tick();
      chk({t, " stray resp"}, 32'({i_ready, d_ready, m_ren, m_wen}), 32'h0);
    end
  endtask

  vec_t vecs[4];
  logic exp_d;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 1'b0,
                1'b1, 1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 32'hAAAA_5555, 2, 1'b0,
                1'b0, 1'b1, 32'h1234_5678, 4'b0011, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h9999_0000, 4'b1111, 32'hCAFE_F00D, 0, 1'b1,
                1'b1, 1'b0, 32'h9999_0000, 4'b1111, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0000_0001, 3, 1'b0,
                1'b1, 1'b0, 32'h0, 4'b1111, 32'h0000_0001};

    // Reset state, then reset in the middle of a data write.
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678; d_bsel = 4'b0011;
    tick();
    chk("pre-reset m_wen", 32'(m_wen), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("midbusy reset");
    reset = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0080;
    tick();
    chk("post-reset m_ren",  32'(m_ren),  32'h1);
    chk("post-reset m_wen",  32'(m_wen),  32'h0);
    chk("post-reset m_addr", m_addr,      32'h0000_0080);
    chk("post-reset m_bsel", 32'(m_bsel), 32'hF);
    m_done = 1'b1; m_rdata = 32'h0BAD_F00D;
    tick();
    chk("post-reset i_ready", 32'(i_ready), 32'h1);
    chk("post-reset i_rdata", i_rdata,      32'h0BAD_F00D);
    i_req = 1'b0; m_done = 1'b0;
    tick();

    // Stray done while idle.
    m_done = 1'b1; m_rdata = 32'h1111_2222;
    tick(); tick();
    chk("stray idle", 32'({i_ready, d_ready, err, m_ren, m_wen}), 32'h0);
    m_done = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Tie: both requesters held high, done on the third busy cycle.
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_2000; d_bsel = 4'b1111; d_wdata = 32'h0;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      chk($sformatf("tie%0d m_addr", g), m_addr, exp_d ? 32'h0000_2000 : 32'h0000_1000);
      tick(); tick();
      m_done = 1'b1; m_rdata = 32'h100 + 32'(g);
      tick();
      chk($sformatf("tie%0d readies", g), 32'({i_ready, d_ready}), exp_d ? 32'h1 : 32'h2);
      m_done = 1'b0;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Watchdog: data read never completed.
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0300; d_bsel = 4'b1111;
    m_rdata = 32'hFEED_FACE;
    tick();
    chk("to grant", 32'(m_ren), 32'h1);
    repeat (7) tick();
    chk("to early", 32'({d_ready, err}), 32'h0);
    tick();
    chk("to d_ready", 32'(d_ready), 32'h1);
    chk("to err",     32'(err),     32'h1);
    chk("to d_rdata", d_rdata,      32'h0);
    chk("to i_ready", 32'(i_ready), 32'h0);
    chk("to port",    32'(m_ren | m_wen), 32'h0);
    d_req = 1'b0;
    tick();
    chk("to err clr", 32'({d_ready, err}), 32'h0);
    run_vec(vecs[2], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
